// File: rtl/matmul_scheduler.sv
// matmul_scheduler: walks an M x N result grid in row-major order and issues
// ceil(K/ADDER_WIDTH) dot-product chunks per result to an external thread.
// Each chunk's partial sum is accumulated, and the finished C[m][n] is
// presented on a valid/ready result port.
// Build option: define MATMUL_SCHED_SATURATE_EN to clamp the accumulator at
// all-ones instead of wrapping.
module matmul_scheduler #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDER_WIDTH = 1,
  parameter int unsigned MAX_DIM     = 16,
  parameter int unsigned DIM_W       = $clog2(MAX_DIM) + 1,
  parameter int unsigned ACC_WIDTH   = 2*DATA_WIDTH + $clog2(MAX_DIM)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DIM_W-1:0]       m_dim,
  input  logic [DIM_W-1:0]       n_dim,
  input  logic [DIM_W-1:0]       k_dim,
  output logic                   busy,
  output logic                   done,
  output logic                   req_valid,
  output logic [DIM_W-1:0]       req_m,
  output logic [DIM_W-1:0]       req_n,
  output logic [DIM_W-1:0]       req_k,
  output logic [ADDER_WIDTH-1:0] req_mask,
  input  logic [ACC_WIDTH-1:0]   part_sum,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DIM_W-1:0]       res_m,
  output logic [DIM_W-1:0]       res_n,
  output logic [ACC_WIDTH-1:0]   res_data
);

  // k + ADDER_WIDTH must not overflow before it is compared with k_dim
  localparam int unsigned KS_W = DIM_W + $clog2(ADDER_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [DIM_W-1:0]       m_dim_q, m_dim_d;
  logic [DIM_W-1:0]       n_dim_q, n_dim_d;
  logic [DIM_W-1:0]       k_dim_q, k_dim_d;
  logic [DIM_W-1:0]       m_q, m_d;
  logic [DIM_W-1:0]       n_q, n_d;
  logic [DIM_W-1:0]       k_q, k_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [ADDER_WIDTH-1:0] mask_q, mask_d;
  logic                   req_valid_q, req_valid_d;
  logic                   res_valid_q, res_valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   dims_ok;
  logic [KS_W-1:0]        k_next;
  logic                   more_k;
  logic                   last_n;
  logic                   last_m;
  logic [ACC_WIDTH-1:0]   acc_add;

  // Job dimensions are legal when every one is in 1..MAX_DIM
  assign dims_ok = (m_dim != '0) && (m_dim <= DIM_W'(MAX_DIM)) &&
                   (n_dim != '0) && (n_dim <= DIM_W'(MAX_DIM)) &&
                   (k_dim != '0) && (k_dim <= DIM_W'(MAX_DIM));

  assign k_next = KS_W'(k_q) + KS_W'(ADDER_WIDTH);
  assign more_k = k_next < KS_W'(k_dim_q);
  assign last_n = (n_q == n_dim_q - DIM_W'(1));
  assign last_m = (m_q == m_dim_q - DIM_W'(1));

`ifdef MATMUL_SCHED_SATURATE_EN
  logic [ACC_WIDTH:0] acc_sum;
  // Clamp: once the carry fires the accumulator pins at all-ones
  always_comb begin
    acc_sum = {1'b0, acc_q} + {1'b0, part_sum};
    acc_add = acc_sum[ACC_WIDTH] ? '1 : acc_sum[ACC_WIDTH-1:0];
  end
`else
  // Wrap modulo 2^ACC_WIDTH
  always_comb begin
    acc_add = acc_q + part_sum;
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = dims_ok ? S_ISSUE : S_DONE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = more_k ? S_ISSUE : S_EMIT;
      S_EMIT:  if (res_ready) state_d = (last_m && last_n) ? S_DONE : S_ISSUE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; flags are decoded from the next state so
  // every port comes straight off a flop
  always_comb begin
    m_dim_d     = m_dim_q;
    n_dim_d     = n_dim_q;
    k_dim_d     = k_dim_q;
    m_d         = m_q;
    n_d         = n_q;
    k_d         = k_q;
    acc_d       = acc_q;
    mask_d      = '0;
    req_valid_d = (state_d == S_ISSUE);
    res_valid_d = (state_d == S_EMIT);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);

    unique case (state_q)
      S_IDLE: begin
        if (start && dims_ok) begin
          m_dim_d = m_dim;
          n_dim_d = n_dim;
          k_dim_d = k_dim;
          m_d     = '0;
          n_d     = '0;
          k_d     = '0;
          acc_d   = '0;
        end
      end
      S_WAIT: begin
        acc_d = acc_add;
        if (more_k) k_d = DIM_W'(k_next);
      end
      S_EMIT: begin
        if (res_ready) begin
          acc_d = '0;
          k_d   = '0;
          if (last_n) begin
            n_d = '0;
            m_d = last_m ? '0 : m_q + DIM_W'(1);
          end else begin
            n_d = n_q + DIM_W'(1);
          end
        end
      end
      default: ;
    endcase

    if (state_d == S_ISSUE) begin
      for (int unsigned i = 0; i < ADDER_WIDTH; i++) begin
        mask_d[i] = (KS_W'(k_d) + KS_W'(i)) < KS_W'(k_dim_d);
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_dim_q     <= '0;
      n_dim_q     <= '0;
      k_dim_q     <= '0;
      m_q         <= '0;
      n_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      mask_q      <= '0;
      req_valid_q <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      m_dim_q     <= m_dim_d;
      n_dim_q     <= n_dim_d;
      k_dim_q     <= k_dim_d;
      m_q         <= m_d;
      n_q         <= n_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      mask_q      <= mask_d;
      req_valid_q <= req_valid_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign req_valid = req_valid_q;
  assign req_m     = m_q;
  assign req_n     = n_q;
  assign req_k     = k_q;
  assign req_mask  = mask_q;
  assign res_valid = res_valid_q;
  assign res_m     = m_q;
  assign res_n     = n_q;
  assign res_data  = acc_q;

endmodule
